// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the two-requester APB command arbiter.
// Used by apb_arbiter_if, apb_arb_req_latch and apb_arbiter.
package apb_arb_pkg;

    localparam int ARB_DW  = 32;
    localparam int NUM_REQ = 2;

    // Read data returned to a requester whose transfer was abandoned by the timeout.
    localparam logic [ARB_DW-1:0] ARB_ERR_DATA = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_t;

    // 0 = requester 0 (CPU), 1 = requester 1 (DMA).
    typedef logic [0:0] req_idx_t;

    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input req_idx_t idx);
        logic [NUM_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/apb_arbiter_if.sv
// Bundle of requester, downstream and status signals around apb_arbiter.
// slave = arbiter view, master = view of the requesters plus downstream APB master.
interface apb_arbiter_if;
    import apb_arb_pkg::*;

    logic              m0_transfer;
    logic [ARB_DW-1:0] m0_addr;
    logic [ARB_DW-1:0] m0_wdata;
    logic              m0_write;
    logic              m0_ready;
    logic [ARB_DW-1:0] m0_rdata;

    logic              m1_transfer;
    logic [ARB_DW-1:0] m1_addr;
    logic [ARB_DW-1:0] m1_wdata;
    logic              m1_write;
    logic              m1_ready;
    logic [ARB_DW-1:0] m1_rdata;

    logic              s_transfer;
    logic [ARB_DW-1:0] s_addr;
    logic [ARB_DW-1:0] s_wdata;
    logic              s_write;
    logic              s_ready;
    logic [ARB_DW-1:0] s_rdata;

    logic [NUM_REQ-1:0] grant;
    logic               timeout_err;

    modport slave (
        input  m0_transfer, m0_addr, m0_wdata, m0_write,
        output m0_ready, m0_rdata,
        input  m1_transfer, m1_addr, m1_wdata, m1_write,
        output m1_ready, m1_rdata,
        output s_transfer, s_addr, s_wdata, s_write,
        input  s_ready, s_rdata,
        output grant, timeout_err
    );

    modport master (
        output m0_transfer, m0_addr, m0_wdata, m0_write,
        input  m0_ready, m0_rdata,
        output m1_transfer, m1_addr, m1_wdata, m1_write,
        input  m1_ready, m1_rdata,
        input  s_transfer, s_addr, s_wdata, s_write,
        output s_ready, s_rdata,
        input  grant, timeout_err
    );

endinterface

// File: rtl/apb_arb_req_latch.sv
// Per-requester pending flag plus captured command (addr/wdata/write).
// A pulse is taken only when nothing is pending; i_clear drops the pending flag.
module apb_arb_req_latch
    import apb_arb_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_transfer,
    input  logic [ARB_DW-1:0] i_addr,
    input  logic [ARB_DW-1:0] i_wdata,
    input  logic              i_write,
    input  logic              i_clear,
    output logic              o_pending,
    output logic [ARB_DW-1:0] o_addr,
    output logic [ARB_DW-1:0] o_wdata,
    output logic              o_write
);

    logic              r_pending;
    logic [ARB_DW-1:0] r_addr;
    logic [ARB_DW-1:0] r_wdata;
    logic              r_write;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pending <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_write   <= 1'b0;
        end else if (i_clear) begin
            r_pending <= 1'b0;
        end else if (i_transfer && !r_pending) begin
            // The command stays frozen while pending so the bus sees a stable copy.
            r_pending <= 1'b1;
            r_addr    <= i_addr;
            r_wdata   <= i_wdata;
            r_write   <= i_write;
        end
    end

    assign o_pending = r_pending;
    assign o_addr    = r_addr;
    assign o_wdata   = r_wdata;
    assign o_write   = r_write;

endmodule

// File: rtl/apb_arbiter.sv
// Round-robin arbiter funnelling two pulsed requesters onto one APB master command port.
// Optional WAIT timeout is compiled in with APB_ARB_TIMEOUT_EN.
module apb_arbiter
    import apb_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic         PCLK,
    input  logic         PRESET,
    apb_arbiter_if.slave bus
);

    arb_state_t r_state;
    arb_state_t w_state_next;

    req_idx_t r_owner;
    req_idx_t r_ptr;
    req_idx_t w_pick;
    logic     w_complete;
    logic     w_timeout;

    logic [NUM_REQ-1:0] w_pending;
    logic [NUM_REQ-1:0] w_clear;
    logic [NUM_REQ-1:0] r_ready;
    logic [ARB_DW-1:0]  r_rdata     [NUM_REQ];

    logic               w_req_transfer [NUM_REQ];
    logic [ARB_DW-1:0]  w_req_addr     [NUM_REQ];
    logic [ARB_DW-1:0]  w_req_wdata    [NUM_REQ];
    logic               w_req_write    [NUM_REQ];
    logic [ARB_DW-1:0]  w_addr         [NUM_REQ];
    logic [ARB_DW-1:0]  w_wdata        [NUM_REQ];
    logic               w_write        [NUM_REQ];

    assign w_req_transfer[0] = bus.m0_transfer;
    assign w_req_addr[0]     = bus.m0_addr;
    assign w_req_wdata[0]    = bus.m0_wdata;
    assign w_req_write[0]    = bus.m0_write;
    assign w_req_transfer[1] = bus.m1_transfer;
    assign w_req_addr[1]     = bus.m1_addr;
    assign w_req_wdata[1]    = bus.m1_wdata;
    assign w_req_write[1]    = bus.m1_write;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign w_clear[gi] = w_complete && (r_owner == req_idx_t'(gi));

            apb_arb_req_latch u_latch (
                .i_clk      (PCLK),
                .i_rst_n    (PRESET),
                .i_transfer (w_req_transfer[gi]),
                .i_addr     (w_req_addr[gi]),
                .i_wdata    (w_req_wdata[gi]),
                .i_write    (w_req_write[gi]),
                .i_clear    (w_clear[gi]),
                .o_pending  (w_pending[gi]),
                .o_addr     (w_addr[gi]),
                .o_wdata    (w_wdata[gi]),
                .o_write    (w_write[gi])
            );
        end
    endgenerate

    // Pointer wins a tie; otherwise the single pending requester is taken.
    assign w_pick = w_pending[r_ptr] ? r_ptr : ~r_ptr;

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_complete   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|w_pending) begin
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.s_ready || w_timeout) begin
                    w_complete   = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            r_owner <= '0;
            r_ptr   <= '0;
            r_ready <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                r_rdata[i] <= '0;
            end
        end else begin
            r_ready <= '0;
            if (r_state == ST_IDLE && |w_pending) begin
                r_owner <= w_pick;
            end
            if (w_complete) begin
                r_ready[r_owner] <= 1'b1;
                r_rdata[r_owner] <= bus.s_ready ? bus.s_rdata : ARB_ERR_DATA;
                r_ptr            <= ~r_owner;
            end
        end
    end

`ifdef APB_ARB_TIMEOUT_EN
    logic [31:0] r_wait_cnt;
    logic        r_timeout_err;

    // Counts completed WAIT cycles; zero on the first WAIT cycle.
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            r_wait_cnt    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= w_timeout;
            if (r_state != ST_WAIT) begin
                r_wait_cnt <= '0;
            end else begin
                r_wait_cnt <= r_wait_cnt + 32'd1;
            end
        end
    end

    assign w_timeout = (r_state == ST_WAIT) && !bus.s_ready &&
                       (r_wait_cnt == TIMEOUT_CYCLES - 32'd1);
    assign bus.timeout_err = r_timeout_err;
`else
    assign w_timeout       = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    assign bus.s_transfer = (r_state == ST_ISSUE);
    assign bus.s_addr     = (r_state == ST_IDLE) ? '0   : w_addr[r_owner];
    assign bus.s_wdata    = (r_state == ST_IDLE) ? '0   : w_wdata[r_owner];
    assign bus.s_write    = (r_state == ST_IDLE) ? 1'b0 : w_write[r_owner];
    assign bus.grant      = (r_state == ST_IDLE) ? '0   : idx_to_onehot(r_owner);

    assign bus.m0_ready = r_ready[0];
    assign bus.m0_rdata = r_rdata[0];
    assign bus.m1_ready = r_ready[1];
    assign bus.m1_rdata = r_rdata[1];

endmodule

// File: tb/tb_apb_arbiter.sv
// Directed bench for apb_arbiter: commands queued at drive time, checked at issue and completion.
// Timeout steps depend on APB_ARB_TIMEOUT_EN.
module tb_apb_arbiter;
    import apb_arb_pkg::*;

    logic PCLK   = 1'b0;
    logic PRESET = 1'b0;

    apb_arbiter_if bus ();

    apb_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (bus)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        int          idx;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        write;
    } cmd_t;

    typedef struct {
        int          idx;
        logic [31:0] rdata;
        logic        terr;
    } cpl_t;

    cmd_t cmd_q[$];
    cpl_t cpl_q[$];

    int          checks    = 0;
    int          failures  = 0;
    int          last_idx  = 0;
    logic [31:0] last_addr = '0;

    task automatic tick;
        @(posedge PCLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input int idx, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic wr, input logic served);
        if (idx == 0) begin
            bus.m0_transfer = 1'b1;
            bus.m0_addr     = addr;
            bus.m0_wdata    = wdata;
            bus.m0_write    = wr;
        end else begin
            bus.m1_transfer = 1'b1;
            bus.m1_addr     = addr;
            bus.m1_wdata    = wdata;
            bus.m1_write    = wr;
        end
        if (served) cmd_q.push_back('{idx, addr, wdata, wr});
    endtask

    task automatic end_pulse;
        tick;
        bus.m0_transfer = 1'b0;
        bus.m1_transfer = 1'b0;
    endtask

    task automatic issue_check(input string tag);
        cmd_t c;
        check({tag, "_queued"}, 32'(cmd_q.size() != 0), 32'd1);
        if (cmd_q.size() == 0) return;
        c = cmd_q.pop_front();
        last_idx  = c.idx;
        last_addr = c.addr;
        $display("issue %s: owner=%0d addr=%h wdata=%h write=%0b grant=%b",
                 tag, c.idx, bus.s_addr, bus.s_wdata, bus.s_write, bus.grant);
        check({tag, "_grant"}, 32'(bus.grant), 32'(1 << c.idx));
        check({tag, "_addr"},  bus.s_addr,  c.addr);
        check({tag, "_wdata"}, bus.s_wdata, c.wdata);
        check({tag, "_write"}, 32'(bus.s_write), 32'(c.write));
    endtask

    task automatic wait_issue(input string tag);
        int n = 0;
        while (bus.s_transfer !== 1'b1 && n < 10) begin
            tick;
            n++;
        end
        check({tag, "_issued"}, 32'(bus.s_transfer), 32'd1);
        if (bus.s_transfer === 1'b1) issue_check(tag);
    endtask

    task automatic check_cpl(input string tag);
        cpl_t c;
        check({tag, "_cplq"}, 32'(cpl_q.size() != 0), 32'd1);
        if (cpl_q.size() == 0) return;
        c = cpl_q.pop_front();
        $display("complete %s: m0_ready=%0b m1_ready=%0b rdata=%h terr=%0b",
                 tag, bus.m0_ready, bus.m1_ready,
                 (c.idx == 0) ? bus.m0_rdata : bus.m1_rdata, bus.timeout_err);
        check({tag, "_ready"}, 32'({bus.m1_ready, bus.m0_ready}), 32'(1 << c.idx));
        check({tag, "_rdata"}, (c.idx == 0) ? bus.m0_rdata : bus.m1_rdata, c.rdata);
        check({tag, "_terr"},  32'(bus.timeout_err), 32'(c.terr));
        check({tag, "_grant_idle"}, 32'(bus.grant), 32'd0);
    endtask

    // Caller sits in the ISSUE cycle or later; delay >= 1 when called from ISSUE.
    task automatic finish_xfer(input int delay, input logic [31:0] rdata, input string tag);
        for (int i = 0; i < delay; i++) begin
            tick;
            check({tag, "_addr_hold"},  bus.s_addr, last_addr);
            check({tag, "_grant_hold"}, 32'(bus.grant), 32'(1 << last_idx));
        end
        bus.s_ready = 1'b1;
        bus.s_rdata = rdata;
        tick;
        bus.s_ready = 1'b0;
        bus.s_rdata = 32'hDEAD_0000;
        cpl_q.push_back('{last_idx, rdata, 1'b0});
        check_cpl(tag);
    endtask

    initial begin
        int cnt;
        bus.m0_transfer = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0; bus.m0_write = 1'b0;
        bus.m1_transfer = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0; bus.m1_write = 1'b0;
        bus.s_ready = 1'b0; bus.s_rdata = '0;
        PRESET = 1'b0;
        tick; tick;

        check("rst_s_transfer", 32'(bus.s_transfer), 32'd0);
        check("rst_grant",      32'(bus.grant), 32'd0);
        check("rst_m0_ready",   32'(bus.m0_ready), 32'd0);
        check("rst_m1_rdata",   bus.m1_rdata, 32'd0);
        check("rst_terr",       32'(bus.timeout_err), 32'd0);
        PRESET = 1'b1;
        tick;

        // m0 write: issue exactly two cycles after the pulse, s_ready three cycles later
        drive_req(0, 32'h1000_0000, 32'h0000_00A5, 1'b1, 1'b1);
        end_pulse;
        check("t1_lat_t1", 32'(bus.s_transfer), 32'd0);
        tick;
        check("t1_lat_t2", 32'(bus.s_transfer), 32'd1);
        issue_check("t1");
        finish_xfer(3, 32'h0000_00C3, "t1");

        // m1 read returns s_rdata; m0 keeps its previous read data
        drive_req(1, 32'h2000_0040, 32'h0, 1'b0, 1'b1);
        end_pulse;
        wait_issue("t2");
        finish_xfer(1, 32'h1234_5678, "t2");
        check("t2_m0_ready_low", 32'(bus.m0_ready), 32'd0);
        check("t2_m0_rdata_hold", bus.m0_rdata, 32'h0000_00C3);

        // new m0 pulse in the m0_ready cycle is captured; repeat pulse in WAIT is dropped
        drive_req(0, 32'h1000_0100, 32'h0000_0011, 1'b1, 1'b1);
        end_pulse;
        wait_issue("t3a");
        finish_xfer(1, 32'h0000_0001, "t3a");
        drive_req(0, 32'h1000_0200, 32'h0000_0022, 1'b1, 1'b1);
        end_pulse;
        check("t3_lat_t1", 32'(bus.s_transfer), 32'd0);
        tick;
        check("t3_lat_t2", 32'(bus.s_transfer), 32'd1);
        issue_check("t3b");
        tick;
        drive_req(0, 32'h1FFF_0000, 32'h0000_00EE, 1'b0, 1'b0);
        end_pulse;
        finish_xfer(2, 32'h0000_0002, "t4");
        cnt = 0;
        repeat (5) begin
            tick;
            if (bus.s_transfer === 1'b1) cnt++;
        end
        check("t4_no_reissue", cnt, 0);

        // simultaneous pulses after reset: m0, m1, then m0 favoured again
        PRESET = 1'b0;
        tick;
        PRESET = 1'b1;
        tick;
        drive_req(0, 32'h4000_0000, 32'h0000_0A0A, 1'b1, 1'b1);
        drive_req(1, 32'h5000_0000, 32'h0000_0B0B, 1'b1, 1'b1);
        end_pulse;
        wait_issue("t5a");
        finish_xfer(1, 32'h0000_0A00, "t5a");
        wait_issue("t5b");
        finish_xfer(2, 32'h0000_0B00, "t5b");
        drive_req(0, 32'h4000_0004, 32'h0000_0C0C, 1'b0, 1'b1);
        drive_req(1, 32'h5000_0004, 32'h0000_0D0D, 1'b0, 1'b1);
        end_pulse;
        wait_issue("t5c");
        finish_xfer(1, 32'h0000_0C00, "t5c");
        wait_issue("t5d");
        finish_xfer(1, 32'h0000_0D00, "t5d");

`ifdef APB_ARB_TIMEOUT_EN
        // s_ready never comes: completion after 8 WAIT cycles with error data
        drive_req(0, 32'h3000_0000, 32'h0, 1'b0, 1'b1);
        end_pulse;
        wait_issue("to");
        cnt = 0;
        repeat (8) begin
            tick;
            if (bus.m0_ready === 1'b1) cnt++;
        end
        check("to_no_early_ready", cnt, 0);
        tick;
        cpl_q.push_back('{0, ARB_ERR_DATA, 1'b1});
        check_cpl("to");
        // timeout advanced the pointer, so m1 now wins the tie
        drive_req(1, 32'h5000_0008, 32'h0000_0E0E, 1'b1, 1'b1);
        drive_req(0, 32'h4000_0008, 32'h0000_0F0F, 1'b1, 1'b1);
        end_pulse;
        wait_issue("to_rr_a");
        finish_xfer(1, 32'h0000_0E00, "to_rr_a");
        wait_issue("to_rr_b");
        finish_xfer(1, 32'h0000_0F00, "to_rr_b");
`else
        // without the timeout, WAIT lasts until s_ready
        drive_req(0, 32'h3000_0000, 32'h0, 1'b0, 1'b1);
        end_pulse;
        wait_issue("nto");
        cnt = 0;
        repeat (30) begin
            tick;
            if (bus.m0_ready === 1'b1 || bus.timeout_err === 1'b1) cnt++;
        end
        check("nto_still_waiting", cnt, 0);
        finish_xfer(0, 32'h5555_AAAA, "nto");
`endif

        // reset in WAIT: outputs drop at once, aborted command never completes
        drive_req(0, 32'h6000_0000, 32'h0000_1234, 1'b1, 1'b1);
        end_pulse;
        wait_issue("t7");
        tick;
        #2 PRESET = 1'b0;
        #1;
        check("t7_s_transfer", 32'(bus.s_transfer), 32'd0);
        check("t7_s_addr",     bus.s_addr, 32'd0);
        check("t7_s_wdata",    bus.s_wdata, 32'd0);
        check("t7_s_write",    32'(bus.s_write), 32'd0);
        check("t7_grant",      32'(bus.grant), 32'd0);
        check("t7_m0_rdata",   bus.m0_rdata, 32'd0);
        check("t7_m1_rdata",   bus.m1_rdata, 32'd0);
        check("t7_terr",       32'(bus.timeout_err), 32'd0);
        tick;
        PRESET      = 1'b1;
        bus.s_ready = 1'b1;
        bus.s_rdata = 32'h7777_7777;
        tick;
        bus.s_ready = 1'b0;
        cnt = 0;
        repeat (8) begin
            if (bus.m0_ready === 1'b1 || bus.s_transfer === 1'b1) cnt++;
            tick;
        end
        check("t7_no_ready", cnt, 0);
        check("t7_m0_rdata_after", bus.m0_rdata, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/apb_arbiter.md
APB_ARBITER -- requirements
Module: apb_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the WAIT cycles without s_ready before abort (used only with APB_ARB_TIMEOUT_EN).
REQ-002 SHALL have port PCLK  in  1  single clock, all state on rising edge.
REQ-003 SHALL have port PRESET  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports m0_transfer in 1, m0_addr in 32, m0_wdata in 32, m0_write in 1 (1 = write, 0 = read): requester 0 (CPU) command.
REQ-005 SHALL have ports m0_ready out 1, m0_rdata out 32: requester 0 completion.
REQ-006 SHALL have ports m1_transfer, m1_addr, m1_wdata, m1_write, m1_ready, m1_rdata, identical to m0_*: requester 1 (DMA).
REQ-007 SHALL have ports s_transfer out 1, s_addr out 32, s_wdata out 32, s_write out 1: command to the downstream APB master.
REQ-008 SHALL have ports s_ready in 1, s_rdata in 32: downstream completion.
REQ-009 SHALL have ports grant out 2 (one-hot owner, 0 when idle) and timeout_err out 1.

Function
REQ-010 SHALL treat mX_transfer as a one-cycle pulse; addr/wdata/write SHALL be captured with it into requester X's pending register.
REQ-011 SHALL ignore an mX_transfer pulse while X is already pending; the original captured command SHALL be kept.
REQ-012 SHALL implement FSM states IDLE, ISSUE and WAIT.
REQ-013 IDLE: SHALL go to ISSUE if any pending bit is set, choosing the owner by round-robin; otherwise SHALL stay in IDLE.
REQ-014 Round-robin: if both are pending, the requester named by the pointer SHALL win; after every completion the pointer SHALL name the other requester.
REQ-015 ISSUE: s_transfer SHALL be 1 for exactly one cycle with the owner's addr/wdata/write, then go to WAIT.
REQ-016 WAIT: s_addr/s_wdata/s_write SHALL hold stable; on s_ready=1, s_rdata SHALL be registered, the pending bit cleared, and the FSM return to IDLE.
REQ-017 The owner's mX_ready SHALL pulse for one cycle in the cycle after s_ready; mX_rdata SHALL be valid in that cycle and held until the next completion.
REQ-018 Uncontended latency: a pulse in cycle t SHALL give s_transfer in cycle t+2.
REQ-019 SHALL ignore s_ready in IDLE and ISSUE.
REQ-020 SHALL capture an mX pulse arriving in the same cycle as mX_ready as a new request.
REQ-021 SHALL capture pulses on both requesters in the same cycle; both SHALL be served in pointer order, one after the other.
REQ-022 SHALL drive grant one-hot in ISSUE/WAIT, and 0 in IDLE.

Reset
REQ-023 With PRESET=0, outputs SHALL be 0 immediately: s_*, mX_ready, mX_rdata, grant, timeout_err.
REQ-024 With PRESET=0, the FSM SHALL go to IDLE, the pointer to 0, and pending bits and captured commands SHALL be cleared.
REQ-025 Reset mid-transfer SHALL abort silently; no mX_ready SHALL be issued for the aborted command.

Configuration
REQ-026 Macro APB_ARB_TIMEOUT_EN defined: a counter SHALL count WAIT cycles; reaching TIMEOUT_CYCLES without s_ready SHALL complete the transfer with mX_ready=1, mX_rdata=32'hFFFF_FFFF and timeout_err=1 for that one cycle, then go to IDLE.
REQ-027 Timeout completion SHALL advance the round-robin pointer as a normal completion does.
REQ-028 Macro APB_ARB_TIMEOUT_EN undefined: no counter; WAIT SHALL last indefinitely; timeout_err SHALL be tied 0.

Structure
REQ-029 Package apb_arb_pkg SHALL hold the state enum typedef, the requester-index typedef, and constant ARB_ERR_DATA = 32'hFFFF_FFFF.
REQ-030 Sub-module apb_arb_req_latch (pending bit plus captured addr/wdata/write, with a clear input) SHALL be instantiated once per requester.

Verification
REQ-031 m0 write pulse, addr 0x1000_0000, wdata 0xA5; s_ready 3 cycles after s_transfer -> s_transfer at t+2; m0_ready 1 cycle after s_ready; grant=01 during the transfer.
REQ-032 m0 and m1 pulse in the same cycle after reset -> m0 served first, then m1; the pointer then favours m0 again.
REQ-033 m1 read with s_rdata=0x1234_5678 -> m1_rdata=0x1234_5678 with m1_ready; m0_ready stays 0.
REQ-034 Second m0 pulse during m0 WAIT with a different addr -> ignored; s_addr keeps the first addr.
REQ-035 APB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, s_ready never asserted -> after 8 WAIT cycles m0_ready=1, m0_rdata=0xFFFF_FFFF, timeout_err=1.
REQ-036 PRESET=0 during WAIT -> all outputs 0 immediately; after release, no m0_ready is seen.
